// File: rtl/divisor8.sv
// Sequential restoring divider for 8-bit unsigned operands, one trial subtraction per clock.
// Contains the ripple subtractor it is built around, followed by the control/register stage.

module subtrator8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] d
);

  logic [8:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign d[i]          = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign d[8] = borrow[8];

endmodule

module divisor8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic [7:0] dividendo,
  input  logic [7:0] divisor,
  output logic       ocupado,
  output logic       pronto,
  output logic [7:0] quociente,
  output logic [7:0] resto,
  output logic       erro_div0
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    DIVIDINDO = 2'd1,
    FIM       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] d_q, d_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quoc_q, quoc_d;
  logic [7:0] resto_q, resto_d;
  logic       erro_q, erro_d;
  logic       pronto_q;
  logic       ocupado_q;

  logic [7:0] shiftS;
  logic [8:0] subD;

  assign shiftS = {r_q[6:0], q_q[7]};

  subtrator8 u_sub (
    .a (shiftS),
    .b (d_q),
    .d (subD)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quoc_d  = quoc_q;
    resto_d = resto_q;
    erro_d  = erro_q;

    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          if (divisor != 8'd0) begin
            r_d     = 8'd0;
            q_d     = dividendo;
            d_d     = divisor;
            cnt_d   = 3'd7;
            state_d = DIVIDINDO;
          end else begin
            // Divide-by-zero skips iteration entirely and reports straight away.
            quoc_d  = 8'hFF;
            resto_d = dividendo;
            erro_d  = 1'b1;
            state_d = FIM;
          end
        end
      end

      DIVIDINDO: begin
        if (!subD[8]) begin
          r_d = subD[7:0];
          q_d = {q_q[6:0], 1'b1};
        end else begin
          r_d = shiftS;
          q_d = {q_q[6:0], 1'b0};
        end
        if (cnt_q == 3'd0) begin
          quoc_d  = q_d;
          resto_d = r_d;
          erro_d  = 1'b0;
          state_d = FIM;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      FIM: begin
        state_d = OCIOSO;
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      r_q       <= 8'd0;
      q_q       <= 8'd0;
      d_q       <= 8'd0;
      cnt_q     <= 3'd0;
      quoc_q    <= 8'd0;
      resto_q   <= 8'd0;
      erro_q    <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      quoc_q    <= quoc_d;
      resto_q   <= resto_d;
      erro_q    <= erro_d;
      pronto_q  <= (state_d == FIM);
      ocupado_q <= (state_d != OCIOSO);
      if (state_q == DIVIDINDO) begin
        assert (r_q[7] == 1'b0);
      end
    end
  end

  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign quociente = quoc_q;
  assign resto     = resto_q;
  assign erro_div0 = erro_q;

endmodule

// File: tb/tb_divisor8.sv
// Self-checking bench for divisor8: directed cases plus a random sweep checked
// against plain-arithmetic division.

module tb_divisor8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inicio;
  logic [7:0] dividendo;
  logic [7:0] divisor;
  logic       ocupado;
  logic       pronto;
  logic [7:0] quociente;
  logic [7:0] resto;
  logic       erro_div0;

  int vectors     = 0;
  int miscompares = 0;
  int cycleCount  = 0;
  int prontoCount = 0;
  int startCycle  = 0;

  divisor8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .dividendo (dividendo),
    .divisor   (divisor),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .quociente (quociente),
    .resto     (resto),
    .erro_div0 (erro_div0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  always @(negedge clk) if (pronto === 1'b1) prontoCount++;

  // While iterating (busy, no result yet) the partial remainder must keep its top bit clear.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ocupado === 1'b1 && pronto === 1'b0) begin
      assert (dut.r_q[7] === 1'b0) else begin
        miscompares++;
        $error("[TB] FAIL r7_invariant: observed %0b expected 0", dut.r_q[7]);
      end
    end
  end

  task automatic compare(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference behaviour straight from the arithmetic definition.
  function automatic void refModel(input int a, input int b,
                                   output int q, output int r, output int e, output int lat);
    if (b == 0) begin
      q = 255; r = a; e = 1; lat = 0;
    end else begin
      q = a / b; r = a % b; e = 0; lat = 8;
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    inicio    = 1'b1;
    dividendo = a;
    divisor   = b;
    @(posedge clk);
    #1;
    startCycle = cycleCount;
    inicio     = 1'b0;
    dividendo  = 8'($urandom);
    divisor    = 8'($urandom);
  endtask

  task automatic checkOutput(input logic [7:0] a, input logic [7:0] b);
    int q, r, e, lat;
    refModel(int'(a), int'(b), q, r, e, lat);
    while (pronto !== 1'b1 && (cycleCount - startCycle) < 20) begin
      @(posedge clk);
      #1;
    end
    compare("latency",   cycleCount - startCycle, lat);
    compare("quociente", int'(quociente), q);
    compare("resto",     int'(resto), r);
    compare("erro_div0", int'(erro_div0), e);
    compare("ocupado_in_fim", int'(ocupado), 1);
    @(posedge clk);
    #1;
    compare("pronto_pulse_end", int'(pronto), 0);
    compare("ocupado_end",      int'(ocupado), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    compare({tag, "_ocupado"},   int'(ocupado), 0);
    compare({tag, "_pronto"},    int'(pronto), 0);
    compare({tag, "_quociente"}, int'(quociente), 0);
    compare({tag, "_resto"},     int'(resto), 0);
    compare({tag, "_erro"},      int'(erro_div0), 0);
  endtask

  initial begin
    int p0;
    logic [7:0] ra, rb;

    rst_n     = 1'b0;
    inicio    = 1'b0;
    dividendo = 8'd0;
    divisor   = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkResetOutputs("reset");

    $display("[TB] idle check");
    p0 = prontoCount;
    repeat (20) @(posedge clk);
    #1;
    compare("idle_pronto_count", prontoCount - p0, 0);
    compare("idle_ocupado", int'(ocupado), 0);

    $display("[TB] directed cases");
    applyStimulus(8'd200, 8'd7);   checkOutput(8'd200, 8'd7);
    applyStimulus(8'd255, 8'd1);   checkOutput(8'd255, 8'd1);
    applyStimulus(8'd5,   8'd9);   checkOutput(8'd5,   8'd9);
    applyStimulus(8'd255, 8'd255); checkOutput(8'd255, 8'd255);
    applyStimulus(8'd0,   8'd3);   checkOutput(8'd0,   8'd3);
    applyStimulus(8'd13,  8'd0);   checkOutput(8'd13,  8'd0);
    applyStimulus(8'd10,  8'd3);   checkOutput(8'd10,  8'd3);

    $display("[TB] request while busy");
    p0 = prontoCount;
    applyStimulus(8'd90, 8'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    inicio    = 1'b1;
    dividendo = 8'd100;
    divisor   = 8'd10;
    @(negedge clk);
    inicio = 1'b0;
    checkOutput(8'd90, 8'd4);
    repeat (12) @(posedge clk);
    #1;
    compare("busy_pronto_count", prontoCount - p0, 1);

    $display("[TB] reset mid-operation");
    applyStimulus(8'd77, 8'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    p0 = prontoCount;
    repeat (12) @(posedge clk);
    #1;
    compare("abort_pronto_count", prontoCount - p0, 0);
    applyStimulus(8'd77, 8'd5);
    checkOutput(8'd77, 8'd5);

    $display("[TB] random sweep");
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      applyStimulus(ra, rb);
      checkOutput(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
